// File: rtl/bus_master_seq.sv
// bus_master_seq: queued initiator for the single-outstanding trans/ready bus.
// Commands are buffered, issued one at a time, and answered in order.
module bus_master_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        trans,
  output logic        write,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        ready,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] PONE = (AW+1)'(1);
  localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

  state_e state_q, state_d;

  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [64:0]   mem_q [0:FIFO_DEPTH-1];
  logic [64:0]   head;
  logic          empty, full, push, pop;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          trans_q, trans_d;
  logic          write_q, write_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_write_q, rsp_write_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          busy_q, busy_d;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // Held low through reset so nothing is accepted before the queue is live.
  assign cmd_ready = ~rst & ~full;
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem_q[rptr_q[AW-1:0]];

  assign wptr_d = push ? wptr_q + PONE : wptr_q;
  assign rptr_d = pop  ? rptr_q + PONE : rptr_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trans_d     = trans_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!empty && !rsp_valid_q) begin
          pop     = 1'b1;
          write_d = head[64];
          addr_d  = head[63:32];
          wdata_d = head[31:0];
          trans_d = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // ready beats the timeout when both land on the same edge
        if (ready) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          rsp_rdata_d = write_q ? 32'h0 : rdata;
          rsp_err_d   = 1'b0;
          trans_d     = 1'b0;
          state_d     = GAP;
        end else if (cnt_q == CLAST) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
          trans_d     = 1'b0;
          state_d     = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (wptr_d != rptr_d) || (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      trans_q     <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      trans_q     <= trans_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign trans     = trans_q;
  assign write     = write_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: doc/bus_master_seq.md
# bus_master_seq

Synthesizable bus master that drives the single-outstanding trans/ready memory bus, the stage directly upstream of the slave memory model. It accepts read/write commands through a valid/ready command port and queues them in a small FIFO. It issues them one at a time on the bus and returns one response per command, with read data or an error flag on timeout. It replaces hand-written initiator tasks so tests can stream traffic into the slave.

## Interface
- FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2
- TIMEOUT, 16, max cycles trans may stay high without ready; >= 1
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  FIFO not full; command accepted when cmd_valid && cmd_ready
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  32  byte address, passed to bus unmodified
- cmd_wdata  input  32  write data; ignored for reads
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
- rsp_write  output  1  type of completed command
- rsp_rdata  output  32  read data; 0 for writes and errors
- rsp_err  output  1  1 = timeout, no ready seen
- trans  output  1  bus transfer request
- write  output  1  bus direction
- addr  output  32  bus address
- wdata  output  32  bus write data
- rdata  input  32  bus read data, valid when ready = 1
- ready  input  1  bus completion strobe, one cycle
- busy  output  1  FIFO non-empty or FSM not IDLE

## Operation
- Command FIFO is registered, with separate read and write pointers that each carry one extra wrap bit. It is full when the pointers differ only in the MSB and empty when they are equal.
- A push and a pop on the same edge are legal whenever the FIFO is non-empty. Occupancy is unchanged.
- FSM states and transitions:
  - IDLE: when the FIFO is non-empty and rsp_valid = 0, pop the head entry. Register write, addr and wdata from it, set trans = 1, clear the timeout counter, and go to REQ.
  - REQ: trans, write, addr and wdata are held stable.
    - If ready = 1 at an edge: capture the response (rsp_rdata = write ? 0 : rdata, rsp_write = write, rsp_err = 0), set rsp_valid = 1, clear trans, and go to GAP.
    - Otherwise the counter increments. When it reaches TIMEOUT: rsp_err = 1, rsp_rdata = 0, rsp_valid = 1, clear trans, and go to GAP.
    - If ready arrives on the same edge the counter would hit TIMEOUT, ready wins and no error is raised.
  - GAP: trans = 0 for exactly one cycle, then go to IDLE. This guarantees the slave sees trans low between transfers.
- Response register: rsp_valid clears on rsp_valid && rsp_ready. No new command issues while rsp_valid = 1, so responses are never overwritten and stay in command order.
- ready seen outside REQ is ignored.
- Counter width is $clog2(TIMEOUT+1) and it saturates; it never wraps.

## Timing
- Reset values (asynchronous, while rst = 1): the FSM is in IDLE and the FIFO is empty.
  - Bus outputs: trans = 0, write = 0, addr = 0, wdata = 0.
  - Response outputs: rsp_valid = 0, rsp_rdata = 0, rsp_write = 0, rsp_err = 0.
  - cmd_ready = 0 while rst is high; cmd_ready = 1 from the first cycle after rst is released.
  - busy = 0.
- Reset mid-transfer drops the in-flight and queued commands. No response is produced.
- Command-to-bus latency: a command accepted at edge N into an empty FIFO, in IDLE with rsp_valid = 0, drives trans = 1 after edge N+1.
- ready sampled at edge E gives rsp_valid = 1 and trans = 0 after edge E. The earliest next trans = 1 is after edge E+2.
- With rsp_ready held at 1, the minimum issue-to-issue spacing is trans-high cycles + 2.
- cmd_ready is combinational from the FIFO full flag only, with no path from cmd_valid.
- All outputs except cmd_ready are registered.

## Test plan
- Single write then read: write addr 0x100, wdata 0xDEADBEEF; then read 0x100. Required: rsp_err = 0 for both, rsp_rdata = 0 for the write, and rsp_rdata = 0xDEADBEEF for the read. trans is low for at least 1 cycle between the two transfers.
- FIFO fill: with rsp_ready = 0, push 6 commands with FIFO_DEPTH = 4. Required: cmd_ready drops after the 5th accept (4 queued + 1 issued). Draining yields 5 responses, then the 6th, all in order.
- Ready wait sweep: slave ready delays of 0, 1, 2 and 3 cycles. Required: trans-high duration equals delay + 1, and response data is correct each time.
- Timeout: slave never asserts ready, TIMEOUT = 16. Required: trans stays high exactly 16 cycles, then rsp_err = 1 and rsp_rdata = 0. The next queued command issues normally.
- Backpressure: hold rsp_ready = 0 for 10 cycles after the first response. Required: no trans while rsp_valid = 1, and the response fields stay stable.
- Reset mid-REQ: assert rst while trans = 1 with 3 queued commands. Required: trans, rsp_valid and busy go to 0 immediately. After release, no stale response appears and cmd_ready = 1.
